edge_bit_packer: RTL and testbench

- Downstream stage of the combined left-right/up-down edge detector.
- Consumes the 1-bit-per-pixel edge stream and packs 8 edge bits per byte, LSB first.
- Buffers packed bytes in a small FIFO and writes them to the output image memory through a valid/ready write port, with incrementing addresses.
- Signals end of frame and exerts back-pressure on the detector's enable.

---
 rtl/edge_pack_pkg.sv | 18 +
 rtl/edge_byte_fifo.sv | 87 ++++++++
 rtl/edge_bit_packer.sv | 155 +++++++++++++++
 tb/tb_edge_bit_packer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pack_pkg.sv
// Shared types and sizing helpers for the edge-bit packing output stage.
package edge_pack_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to count from 0 up to and including the pixel total.
    function automatic int pix_cnt_width(input int pixels);
        return $clog2(pixels + 1);
    endfunction

endpackage

// File: rtl/edge_byte_fifo.sv
// Small synchronous byte FIFO with a flopped head; a push into a full FIFO
// without a simultaneous pop is discarded here and reported by the caller.
module edge_byte_fifo
    import edge_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [BYTE_BITS-1:0]             din,
    output logic [BYTE_BITS-1:0]             dout,
    output logic [$clog2(FIFO_DEPTH):0]      count,
    output logic                             full,
    output logic                             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [BYTE_BITS-1:0] dout_r;

    logic                 empty_s;
    logic                 full_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;
    logic [PTR_W-1:0]     rd_next_s;
    logic [BYTE_BITS-1:0] head_next_s;

    assign count = count_r;
    assign dout  = dout_r;
    assign full  = full_s;
    assign empty = empty_s;

    // Accept/pop qualification and the value the head register takes next.
    always_comb begin
        empty_s     = (count_r == '0);
        full_s      = (count_r == CNT_W'(FIFO_DEPTH));
        pop_ok_s    = pop && !empty_s;
        push_ok_s   = push && (!full_s || pop_ok_s);
        rd_next_s   = rd_ptr_r + PTR_W'(1);
        head_next_s = dout_r;
        if (pop_ok_s) begin
            // With only one entry left, the next head can only be the incoming byte.
            if (count_r == CNT_W'(1)) begin
                head_next_s = push_ok_s ? din : dout_r;
            end else begin
                head_next_s = mem_r[rd_next_s];
            end
        end else begin
            if (empty_s && push_ok_s) begin
                head_next_s = din;
            end else begin
                head_next_s = dout_r;
            end
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            dout_r   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
            dout_r  <= head_next_s;
        end
    end

endmodule

// File: rtl/edge_bit_packer.sv
// Packs the 1-bit edge stream LSB-first into bytes and writes them out through
// a valid/ready port at incrementing addresses, with end-of-frame signalling.
module edge_bit_packer
    import edge_pack_pkg::*;
#(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 enb,
    input  logic                 edge_in,
    input  logic                 flush,
    output logic                 stall,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BYTE_BITS-1:0] mem_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int PIXELS = IMG_W * IMG_H;
    localparam int PIX_W  = pix_cnt_width(PIXELS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 1);

    state_t               state_r;
    logic [2:0]           bit_cnt_r;
    logic [BYTE_BITS-1:0] shreg_r;
    logic [PIX_W-1:0]     pix_cnt_r;
    logic [ADDR_W-1:0]    wr_addr_r;
    logic                 busy_r;
    logic                 frame_done_r;
    logic                 overflow_r;

    logic                 accum_s;
    logic [2:0]           bit_next_s;
    logic [BYTE_BITS-1:0] cur_byte_s;
    logic                 last_pix_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 to_drain_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [BYTE_BITS-1:0] fifo_dout_s;

    edge_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (cur_byte_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign stall      = (fifo_count_s >= STALL_LVL);
    assign mem_valid  = !fifo_empty_s;
    assign mem_data   = fifo_dout_s;
    assign mem_addr   = wr_addr_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

    // Byte assembly and push/pop decisions for the current cycle.
    always_comb begin
        accum_s    = (state_r == ACCUM);
        bit_next_s = enb ? (bit_cnt_r + 3'd1) : bit_cnt_r;
        // shreg_r is cleared after every push, so bits above bit_cnt_r are already zero.
        cur_byte_s = shreg_r | (enb ? ({7'd0, edge_in} << bit_cnt_r) : 8'd0);
        last_pix_s = enb && (pix_cnt_r == PIX_LAST);
        push_s     = accum_s && ((enb && (bit_cnt_r == 3'd7)) || last_pix_s ||
                                 (flush && (bit_next_s != 3'd0)));
        to_drain_s = accum_s && (flush || last_pix_s);
        pop_s      = !fifo_empty_s && mem_ready;
        drop_s     = push_s && fifo_full_s && !pop_s;
    end

    // Frame sequencing, counters, write address and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shreg_r      <= '0;
            pix_cnt_r    <= '0;
            wr_addr_r    <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (pop_s) begin
                wr_addr_r <= wr_addr_r + ADDR_W'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bit_cnt_r  <= 3'd0;
                        pix_cnt_r  <= '0;
                        shreg_r    <= '0;
                        wr_addr_r  <= base_addr;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (enb) begin
                        bit_cnt_r <= bit_next_s;
                        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
                    end
                    if (push_s) begin
                        shreg_r <= '0;
                    end else if (enb) begin
                        shreg_r <= cur_byte_s;
                    end
                    if (to_drain_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty_s) begin
                        frame_done_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_bit_packer.sv
// Directed bench: a small 8x2 instance for byte/flush/wrap cases and a
// default 64x64 instance for back-pressure, overflow and mid-frame reset.
module tb_edge_bit_packer;

    logic        clk;
    logic        reset;

    logic        s_start, s_enb, s_edge, s_flush, s_ready;
    logic [15:0] s_base;
    logic        s_stall, s_valid, s_busy, s_done, s_ovf;
    logic [15:0] s_addr;
    logic [7:0]  s_data;

    logic        b_start, b_enb, b_edge, b_flush, b_ready;
    logic [15:0] b_base;
    logic        b_stall, b_valid, b_busy, b_done, b_ovf;
    logic [15:0] b_addr;
    logic [7:0]  b_data;

    int          n_checks;
    int          n_errors;

    logic [15:0] s_aq[$];
    logic [7:0]  s_dq[$];
    int          s_done_cnt;
    logic [15:0] b_aq[$];
    logic [7:0]  b_dq[$];
    int          b_done_cnt;
    int          b_valid_cyc;

    edge_bit_packer #(
        .IMG_W (8), .IMG_H (2), .FIFO_DEPTH (4), .ADDR_W (16)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .start      (s_start),
        .base_addr  (s_base),
        .enb        (s_enb),
        .edge_in    (s_edge),
        .flush      (s_flush),
        .stall      (s_stall),
        .mem_valid  (s_valid),
        .mem_ready  (s_ready),
        .mem_addr   (s_addr),
        .mem_data   (s_data),
        .busy       (s_busy),
        .frame_done (s_done),
        .overflow   (s_ovf)
    );

    edge_bit_packer u_big (
        .clk        (clk),
        .reset      (reset),
        .start      (b_start),
        .base_addr  (b_base),
        .enb        (b_enb),
        .edge_in    (b_edge),
        .flush      (b_flush),
        .stall      (b_stall),
        .mem_valid  (b_valid),
        .mem_ready  (b_ready),
        .mem_addr   (b_addr),
        .mem_data   (b_data),
        .busy       (b_busy),
        .frame_done (b_done),
        .overflow   (b_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change at posedge+1, so a negedge sample of valid&&ready is an accepted write.
    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            s_aq.push_back(s_addr);
            s_dq.push_back(s_data);
        end
        if (s_done) s_done_cnt++;
        if (b_valid && b_ready) begin
            b_aq.push_back(b_addr);
            b_dq.push_back(b_data);
        end
        if (b_done) b_done_cnt++;
        if (b_valid) b_valid_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic big_bit(input int p);
        return ((p % 3) == 0) ? 1'b1 : p[4];
    endfunction

    function automatic logic [7:0] big_byte(input int n);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = big_bit(8 * n + k);
        return v;
    endfunction

    task automatic s_start_frame(input logic [15:0] base);
        s_base  = base;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic b_start_frame(input logic [15:0] base);
        b_base  = base;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    task automatic s_run_bits(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            s_enb  = 1'b1;
            s_edge = pat[i];
            tick();
        end
        s_enb  = 1'b0;
        s_edge = 1'b0;
    endtask

    task automatic s_flush_pulse();
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
    endtask

    task automatic s_wait_done(input string tag);
        int d0;
        d0 = s_done_cnt;
        for (int i = 0; i < 200; i++) begin
            if (s_done_cnt != d0) break;
            tick();
        end
        check({tag, "_done"}, s_done_cnt - d0, 1);
        check({tag, "_idle"}, s_busy, 1'b0);
        repeat (3) tick();
        check({tag, "_once"}, s_done_cnt - d0, 1);
    endtask

    task automatic b_wait_done(input string tag);
        int d0;
        d0 = b_done_cnt;
        for (int i = 0; i < 3000; i++) begin
            if (b_done_cnt != d0) break;
            tick();
        end
        check({tag, "_done"}, b_done_cnt - d0, 1);
        check({tag, "_idle"}, b_busy, 1'b0);
    endtask

    initial begin
        int n0;
        int p;
        int d0;
        int v0;
        bit seen;

        n_checks = 0;   n_errors = 0;
        s_done_cnt = 0; b_done_cnt = 0; b_valid_cyc = 0;
        reset = 1'b0;
        s_start = 1'b0; s_enb = 1'b0; s_edge = 1'b0; s_flush = 1'b0; s_ready = 1'b0; s_base = 16'h0000;
        b_start = 1'b0; b_enb = 1'b0; b_edge = 1'b0; b_flush = 1'b0; b_ready = 1'b0; b_base = 16'h0000;

        #1 reset = 1'b1;
        #1;
        check("rst_valid", {s_valid, b_valid}, 2'b00);
        check("rst_stall", {s_stall, b_stall}, 2'b00);
        check("rst_busy",  {s_busy, b_busy}, 2'b00);
        check("rst_done",  {s_done, b_done}, 2'b00);
        check("rst_ovf",   {s_ovf, b_ovf}, 2'b00);
        check("rst_addr",  s_addr, 16'h0000);
        check("rst_data",  s_data, 8'h00);
        tick();
        reset = 1'b0;
        tick();

        // Two full bytes from a 16-pixel frame.
        s_ready = 1'b1;
        n0 = s_aq.size();
        s_start_frame(16'h0100);
        check("t1_busy", s_busy, 1'b1);
        s_run_bits(16'hFF8D, 16);
        s_wait_done("t1");
        check("t1_nwr", s_aq.size() - n0, 2);
        if (s_aq.size() - n0 == 2) begin
            check("t1_a0", s_aq[n0],     16'h0100);
            check("t1_d0", s_dq[n0],     8'h8D);
            check("t1_a1", s_aq[n0 + 1], 16'h0101);
            check("t1_d1", s_dq[n0 + 1], 8'hFF);
        end

        // Early flush with a 3-bit partial byte.
        n0 = s_aq.size();
        s_start_frame(16'h0040);
        s_run_bits(16'h0003, 3);
        s_flush_pulse();
        s_wait_done("t2");
        check("t2_nwr", s_aq.size() - n0, 1);
        if (s_aq.size() - n0 == 1) begin
            check("t2_a0", s_aq[n0], 16'h0040);
            check("t2_d0", s_dq[n0], 8'h03);
        end

        // Flush at a byte boundary writes nothing.
        n0 = s_aq.size();
        s_start_frame(16'h0050);
        s_flush_pulse();
        s_wait_done("t2b");
        check("t2b_nwr", s_aq.size() - n0, 0);

        // Address wraps at the top of the address space.
        n0 = s_aq.size();
        s_start_frame(16'hFFFF);
        s_run_bits(16'h5AA5, 16);
        s_wait_done("t3");
        check("t3_nwr", s_aq.size() - n0, 2);
        if (s_aq.size() - n0 == 2) begin
            check("t3_a0", s_aq[n0],     16'hFFFF);
            check("t3_d0", s_dq[n0],     8'hA5);
            check("t3_a1", s_aq[n0 + 1], 16'h0000);
            check("t3_d1", s_dq[n0 + 1], 8'h5A);
        end

        // Back-pressure: upstream honours stall, memory stalled for 40 cycles.
        n0 = b_aq.size();
        b_ready = 1'b0;
        b_start_frame(16'h2000);
        p = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && p < 4096; cyc++) begin
            if (!seen && b_stall) begin
                seen = 1'b1;
                check("t4_stall_at3", p, 24);
            end
            if (cyc == 39) begin
                check("t4_hold_valid", b_valid, 1'b1);
                check("t4_hold_addr",  b_addr, 16'h2000);
                check("t4_hold_data",  b_data, big_byte(0));
            end
            b_ready = (cyc >= 40);
            b_enb   = !b_stall;
            b_edge  = big_bit(p);
            tick();
            if (b_enb) p++;
        end
        b_enb = 1'b0;
        check("t4_stall_seen", seen, 1'b1);
        check("t4_pixels", p, 4096);
        b_wait_done("t4");
        check("t4_ovf", b_ovf, 1'b0);
        check("t4_nwr", b_aq.size() - n0, 512);
        if (b_aq.size() - n0 == 512) begin
            for (int n = 0; n < 512; n++) begin
                check($sformatf("t4_a%0d", n), b_aq[n0 + n], 16'h2000 + 16'(n));
                check($sformatf("t4_d%0d", n), b_dq[n0 + n], big_byte(n));
            end
        end

        // Overflow: enb ignores stall, fifth byte is dropped.
        n0 = b_aq.size();
        b_ready = 1'b0;
        b_start_frame(16'h0000);
        b_edge = 1'b1;
        b_enb  = 1'b1;
        repeat (32) tick();
        check("t5_ovf_before", b_ovf, 1'b0);
        repeat (8) tick();
        b_enb = 1'b0;
        check("t5_ovf_after", b_ovf, 1'b1);
        b_ready = 1'b1;
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        b_wait_done("t5");
        check("t5_sticky", b_ovf, 1'b1);
        check("t5_nwr", b_aq.size() - n0, 4);
        if (b_aq.size() - n0 == 4) begin
            check("t5_a3", b_aq[n0 + 3], 16'h0003);
            check("t5_d3", b_dq[n0 + 3], 8'hFF);
        end
        b_start_frame(16'h0300);
        check("t5_start_clr", b_ovf, 1'b0);

        // Reset mid-frame with two bytes queued.
        b_ready = 1'b0;
        b_edge  = 1'b1;
        b_enb   = 1'b1;
        repeat (16) tick();
        b_enb = 1'b0;
        check("t6_queued", b_valid, 1'b1);
        check("t6_busy", b_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", b_valid, 1'b0);
        check("t6_addr",  b_addr, 16'h0000);
        check("t6_data",  b_data, 8'h00);
        check("t6_busy0", b_busy, 1'b0);
        check("t6_stall", b_stall, 1'b0);
        check("t6_ovf",   {b_ovf, b_done}, 2'b00);
        tick();
        reset = 1'b0;
        d0 = b_done_cnt;
        v0 = b_valid_cyc;
        b_ready = 1'b1;
        b_enb   = 1'b1;
        repeat (12) tick();
        b_enb = 1'b0;
        check("t6_no_valid", b_valid_cyc - v0, 0);
        check("t6_no_done", b_done_cnt - d0, 0);
        check("t6_idle", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
